// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and constants for the controller responder
package controller_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCHED  = 2'd1,
        SHIFTING = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int CONTROLLER_BITS = 8;
    localparam int CNT_W           = 4;

    // Counter value just before the final shift of a frame
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CONTROLLER_BITS - 1);

endpackage

// File: rtl/sync_edge_m.sv
// rtl/sync_edge_m.sv - multi-stage synchronizer with rise/fall edge pulses
//
// Brings an asynchronous pin into the clk_in domain through SYNC_STAGES flops,
// then compares against one history flop to produce single-cycle edge pulses.
//
// Ports:
//   clk_in   in   system clock
//   rst      in   asynchronous active-high reset
//   async_in in   asynchronous input pin
//   level    out  synchronized level
//   rise     out  one-cycle pulse on a synchronized rising edge
//   fall     out  one-cycle pulse on a synchronized falling edge
module sync_edge_m #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/controller_responder_m.sv
// rtl/controller_responder_m.sv - NES-style controller emulator driven by a console-side reader
//
// Emulates one 4021-style parallel-in/serial-out shift register per controller.
// While the latch is high the button state is loaded continuously; the value
// present on the latch falling edge is the frame, shifted out MSB-first on each
// controller_clk rising edge. Data lines are active-low and idle high.
//
// Optional feature macro: CONTROLLER_RESPONDER_TURBO_EN
//   Adds turbo_mask_LIST and TURBO_PERIOD. Masked buttons read pressed only on
//   the first TURBO_PERIOD of every 2*TURBO_PERIOD frames.
//
// Ports:
//   clk_in                  in   system clock (>= 4x controller_clk toggle rate)
//   rst                     in   asynchronous active-high reset
//   controller_clk          in   serial shift clock from the reader (async)
//   controller_latch        in   parallel-load strobe from the reader (async)
//   buttons_in_LIST         in   active-high buttons, controller n at [8n+:8], bit 7 first
//   turbo_mask_LIST         in   turbo-enabled buttons (only with the macro)
//   controller_data_B_LIST  out  active-low serial data, one per controller
//   latch_done              out  one-cycle pulse on a synchronized latch falling edge
//   shift_done              out  one-cycle pulse on the 8th shift after a latch
module controller_responder_m
    import controller_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int SYNC_STAGES     = 2
`ifdef CONTROLLER_RESPONDER_TURBO_EN
    ,
    parameter int TURBO_PERIOD    = 4
`endif
) (
    input  logic                                         clk_in,
    input  logic                                         rst,
    input  logic                                         controller_clk,
    input  logic                                         controller_latch,
    input  logic [CONTROLLER_BITS*NUM_CONTROLLERS-1:0]   buttons_in_LIST,
`ifdef CONTROLLER_RESPONDER_TURBO_EN
    input  logic [CONTROLLER_BITS*NUM_CONTROLLERS-1:0]   turbo_mask_LIST,
`endif
    output logic [NUM_CONTROLLERS-1:0]                   controller_data_B_LIST,
    output logic                                         latch_done,
    output logic                                         shift_done
);

    logic clk_level, clk_rise, clk_fall;
    logic latch_level, latch_rise, latch_fall;

    sync_edge_m #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .async_in (controller_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    sync_edge_m #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .async_in (controller_latch),
        .level    (latch_level),
        .rise     (latch_rise),
        .fall     (latch_fall)
    );

    // Only the rising edge of the shift clock matters
    logic unused_clk;
    assign unused_clk = clk_level ^ clk_fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_en, shift_en;
    logic             latch_done_d, shift_done_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_en     = 1'b0;
        latch_done_d = 1'b0;
        shift_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (latch_level) state_d = LATCHED;
            end
            LATCHED: begin
                // Clock edges are ignored here, including one coincident with the fall
                if (latch_fall) begin
                    state_d      = SHIFTING;
                    cnt_d        = '0;
                    latch_done_d = 1'b1;
                end
            end
            SHIFTING: begin
                // A latch rise beats a coincident clock rise and aborts the frame
                if (latch_rise) begin
                    state_d = LATCHED;
                    cnt_d   = '0;
                end else if (clk_rise) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == SHIFT_LAST) begin
                        state_d      = DONE;
                        shift_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (latch_rise) begin
                    state_d = LATCHED;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load while in LATCHED (including the fall cycle, which captures the frame)
    // and on entry, so the first bit is on the line before any clock edge.
    assign load_en = (state_q == LATCHED) || (state_d == LATCHED);

    logic drive_data;
    assign drive_data = (state_d == LATCHED) || (state_d == SHIFTING);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            latch_done <= 1'b0;
            shift_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            latch_done <= latch_done_d;
            shift_done <= shift_done_d;
        end
    end

`ifdef CONTROLLER_RESPONDER_TURBO_EN
    localparam int TURBO_W = (2 * TURBO_PERIOD > 2) ? $clog2(2 * TURBO_PERIOD) : 1;
    localparam logic [TURBO_W-1:0] FRAME_LAST = TURBO_W'(2 * TURBO_PERIOD - 1);
    localparam logic [TURBO_W-1:0] PHASE_END  = TURBO_W'(TURBO_PERIOD);

    logic [TURBO_W-1:0] frame_cnt_q;
    logic               turbo_phase;

    // Counts captured frames; the frame being loaded uses the count before its fall
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (latch_done_d) begin
            frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + TURBO_W'(1);
        end
    end

    assign turbo_phase = (frame_cnt_q < PHASE_END);
`endif

    for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_ctrl
        logic [CONTROLLER_BITS-1:0] load_val;
        logic [CONTROLLER_BITS-1:0] shift_q, shift_d;
        logic                       data_b_q;

`ifdef CONTROLLER_RESPONDER_TURBO_EN
        assign load_val = buttons_in_LIST[CONTROLLER_BITS*g +: CONTROLLER_BITS]
                        & ~(turbo_mask_LIST[CONTROLLER_BITS*g +: CONTROLLER_BITS]
                            & {CONTROLLER_BITS{~turbo_phase}});
`else
        assign load_val = buttons_in_LIST[CONTROLLER_BITS*g +: CONTROLLER_BITS];
`endif

        always_comb begin
            shift_d = shift_q;
            if (load_en)       shift_d = load_val;
            else if (shift_en) shift_d = {shift_q[CONTROLLER_BITS-2:0], 1'b0};
        end

        // Output follows the next register value so data is aligned with the state
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                shift_q  <= '0;
                data_b_q <= 1'b1;
            end else begin
                shift_q  <= shift_d;
                data_b_q <= drive_data ? ~shift_d[CONTROLLER_BITS-1] : 1'b1;
            end
        end

        assign controller_data_B_LIST[g] = data_b_q;
    end

endmodule

// File: tb/tb_controller_responder_m.sv
// tb/tb_controller_responder_m.sv - self-checking bench for controller_responder_m
module tb_controller_responder_m;

    localparam int NC = 2;

    logic            clk_in = 1'b0;
    logic            rst;
    logic            controller_clk;
    logic            controller_latch;
    logic [8*NC-1:0] buttons_in_LIST;
`ifdef CONTROLLER_RESPONDER_TURBO_EN
    logic [8*NC-1:0] turbo_mask_LIST;
`endif
    logic [NC-1:0]   controller_data_B_LIST;
    logic            latch_done;
    logic            shift_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_latch = 0;
    int n_shift = 0;

    controller_responder_m #(
        .NUM_CONTROLLERS (NC),
        .SYNC_STAGES     (2)
`ifdef CONTROLLER_RESPONDER_TURBO_EN
        ,
        .TURBO_PERIOD    (2)
`endif
    ) dut (
        .clk_in                 (clk_in),
        .rst                    (rst),
        .controller_clk         (controller_clk),
        .controller_latch       (controller_latch),
        .buttons_in_LIST        (buttons_in_LIST),
`ifdef CONTROLLER_RESPONDER_TURBO_EN
        .turbo_mask_LIST        (turbo_mask_LIST),
`endif
        .controller_data_B_LIST (controller_data_B_LIST),
        .latch_done             (latch_done),
        .shift_done             (shift_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        #1;
        if (latch_done) n_latch++;
        if (shift_done) n_shift++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic do_latch();
        controller_latch = 1'b1;
        cyc(6);
        controller_latch = 1'b0;
        cyc(6);
    endtask

    task automatic do_clk();
        controller_clk = 1'b1;
        cyc(4);
        controller_clk = 1'b0;
        cyc(4);
    endtask

    // Reader's view: sample k of a frame is the inverted button (7-k), then idle-high
    function automatic logic [NC-1:0] exp_bits(input logic [8*NC-1:0] frame, input int k);
        logic [NC-1:0] r;
        for (int n = 0; n < NC; n++)
            r[n] = (k < 8) ? ~frame[8*n + 7 - k] : 1'b1;
        return r;
    endfunction

    // Sample nbits bits, pulsing the clock after each; optionally change buttons mid-frame
    task automatic read_bits(input string tag, input logic [8*NC-1:0] frame, input int first_k,
                             input int nbits, input int chg_k, input logic [8*NC-1:0] new_b);
        for (int k = first_k; k < first_k + nbits; k++) begin
            if (k == chg_k) buttons_in_LIST = new_b;
            chk($sformatf("%s bit%0d", tag, k), controller_data_B_LIST, exp_bits(frame, k));
            do_clk();
        end
    endtask

    initial begin
        int s0, l0;
        logic [8*NC-1:0] b1, b2;

        rst              = 1'b1;
        controller_clk   = 1'b0;
        controller_latch = 1'b0;
        buttons_in_LIST  = 16'hA5A5;
`ifdef CONTROLLER_RESPONDER_TURBO_EN
        turbo_mask_LIST  = '0;
`endif
        cyc(3);
        chk("reset data_B", controller_data_B_LIST, 2'b11);
        chk("reset latch_done", latch_done, 1'b0);
        chk("reset shift_done", shift_done, 1'b0);
        rst = 1'b0;
        cyc(2);

        // Clocks with no latch are ignored
        s0 = n_shift;
        repeat (3) do_clk();
        chk("idle clocks data_B", controller_data_B_LIST, 2'b11);
        chk("idle clocks shift_done", n_shift - s0, 0);

        // Directed frame, 10 clocks (bits 8-9 read released)
        buttons_in_LIST = {8'h3C, 8'hA5};
        s0 = n_shift; l0 = n_latch;
        do_latch();
        read_bits("directed", 16'h3CA5, 0, 10, -1, '0);
        chk("directed latch_done count", n_latch - l0, 1);
        chk("directed shift_done count", n_shift - s0, 1);

        // Abort after 3 clocks, re-latch with all pressed
        b1 = 16'($urandom);
        buttons_in_LIST = b1;
        s0 = n_shift; l0 = n_latch;
        do_latch();
        read_bits("abort first", b1, 0, 3, -1, '0);
        buttons_in_LIST = 16'hFFFF;
        do_latch();
        read_bits("abort second", 16'hFFFF, 0, 9, -1, '0);
        chk("abort latch_done count", n_latch - l0, 2);
        chk("abort shift_done count", n_shift - s0, 1);

        // Buttons change mid-shift without affecting the frame in flight
        buttons_in_LIST = 16'h8181;
        s0 = n_shift;
        do_latch();
        read_bits("midchange", 16'h8181, 0, 10, 3, 16'h0000);
        chk("midchange shift_done count", n_shift - s0, 1);

        // Clock rising together with latch falling is ignored
        b1 = 16'($urandom);
        buttons_in_LIST = b1;
        s0 = n_shift;
        controller_latch = 1'b1;
        cyc(6);
        controller_latch = 1'b0;
        controller_clk   = 1'b1;
        cyc(4);
        controller_clk   = 1'b0;
        cyc(4);
        read_bits("clk at fall", b1, 0, 9, -1, '0);
        chk("clk at fall shift_done count", n_shift - s0, 1);

        // Clock rising together with latch rising mid-frame: latch wins
        b1 = 16'($urandom);
        b2 = 16'($urandom);
        buttons_in_LIST = b1;
        s0 = n_shift;
        do_latch();
        read_bits("clk at rise old", b1, 0, 2, -1, '0);
        buttons_in_LIST  = b2;
        controller_latch = 1'b1;
        controller_clk   = 1'b1;
        cyc(6);
        controller_latch = 1'b0;
        controller_clk   = 1'b0;
        cyc(6);
        read_bits("clk at rise new", b2, 0, 9, -1, '0);
        chk("clk at rise shift_done count", n_shift - s0, 1);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            b1 = 16'($urandom);
            buttons_in_LIST = b1;
            s0 = n_shift;
            do_latch();
            read_bits($sformatf("rand%0d", f), b1, 0, 10, -1, '0);
            chk($sformatf("rand%0d shift_done count", f), n_shift - s0, 1);
        end

        // Reset mid-frame forces lines high without waiting for a clock edge
        buttons_in_LIST = 16'h0000;
        do_latch();
        read_bits("pre-reset", 16'h0000, 0, 3, -1, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset data_B", controller_data_B_LIST, 2'b11);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        s0 = n_shift;
        repeat (3) do_clk();
        chk("post-reset idle data_B", controller_data_B_LIST, 2'b11);
        chk("post-reset shift_done count", n_shift - s0, 0);

`ifdef CONTROLLER_RESPONDER_TURBO_EN
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        turbo_mask_LIST = 16'h8080;
        buttons_in_LIST = 16'h8080;
        for (int f = 0; f < 5; f++) begin
            logic on_phase;
            on_phase = ((f % 4) < 2);
            b1 = buttons_in_LIST & ~(turbo_mask_LIST & {16{~on_phase}});
            do_latch();
            read_bits($sformatf("turbo%0d", f), b1, 0, 9, -1, '0);
        end
        turbo_mask_LIST = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controller_responder_m.md
Name: controller_responder_m

Overview:
- Device-side end of the serial controller link: emulates NES-style controllers (4021-type parallel-in/serial-out) for one or more ports.
- Accepts latch and controller clock from a console-side reader.
- Shifts out button state MSB-first on active-low data lines, one line per controller.
- Used for board-level loopback against the controller reader, and for adapters that feed host-supplied button state into the console.

Parameters:
- NUM_CONTROLLERS, 2, number of emulated controllers; each has its own data line and 8-bit button input.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on controller_clk and controller_latch (minimum 2).

Ports:
- clk_in  input  1  system clock; must be at least 4x the controller_clk toggle rate.
- rst  input  1  asynchronous, active-high reset.
- controller_clk  input  1  serial shift clock from the reader (asynchronous to clk_in).
- controller_latch  input  1  parallel-load strobe from the reader (asynchronous to clk_in).
- buttons_in_LIST  input  8*NUM_CONTROLLERS  active-high button state; controller n occupies [8n+:8], bit 7 is shifted first.
- controller_data_B_LIST  output  NUM_CONTROLLERS  active-low serial data, one bit per controller.
- latch_done  output  1  one-cycle pulse when a synchronized latch falling edge is detected.
- shift_done  output  1  one-cycle pulse on the 8th synchronized controller_clk rising edge after a latch.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, shift registers=0, bit counter=0.
  - controller_data_B_LIST=all 1s, latch_done=0, shift_done=0.
- Inputs:
  - controller_clk and controller_latch each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Edge detection is clocked on posedge clk_in.
  - Latency from pin to internal action is SYNC_STAGES+1 clk_in cycles.
- State machine (posedge clk_in):
  - IDLE: synced latch high -> LATCHED.
  - LATCHED:
    - Every cycle, shift_reg[n] <= buttons_in_LIST[n] (continuous parallel load, as the 4021 does).
    - Synced latch falling edge -> SHIFTING, bit counter=0, latch_done=1 for one cycle.
    - The value loaded on that cycle is the captured frame.
  - SHIFTING:
    - Each synced controller_clk rising edge: shift_reg <= {shift_reg[6:0],1'b0}, counter+1.
    - On the edge that makes counter=8: -> DONE, shift_done=1 for one cycle.
  - DONE: synced latch high -> LATCHED.
- Data output:
  - In LATCHED and SHIFTING: controller_data_B[n] = ~shift_reg[n][7] (registered).
  - In IDLE and DONE: controller_data_B[n] = 1.
  - The first bit is valid before the first clock edge, as the reader requires.
- Boundary conditions:
  - Latch rising in SHIFTING or DONE aborts the current frame: -> LATCHED, counter cleared, no shift_done.
  - Clock edges in IDLE, LATCHED or DONE are ignored; the counter never exceeds 8.
  - A clock rising edge coincident with a latch rising edge is ignored; the latch wins.
  - A clock edge coincident with the latch falling edge is ignored; shifting starts from the next edge.
  - buttons_in_LIST changes during SHIFTING have no effect on the frame in flight.
  - Reset asserted mid-frame forces data lines high immediately (async) and returns to IDLE.

Optional Feature:
- Macro: CONTROLLER_RESPONDER_TURBO_EN.
- Defined: adds input turbo_mask_LIST (8*NUM_CONTROLLERS) and parameter TURBO_PERIOD (default 4).
  - A frame counter counts latch_done pulses, modulo 2*TURBO_PERIOD.
  - A turbo phase bit is high for the first TURBO_PERIOD frames.
  - Loaded value = buttons_in & ~(turbo_mask & ~phase).
  - Masked buttons therefore read pressed only in the on-phase.
  - The counter resets to 0.
- Undefined: no port or parameter; loaded value = buttons_in.

Decomposition:
- Package controller_pkg:
  - state enum {IDLE, LATCHED, SHIFTING, DONE} (2 bits).
  - CONTROLLER_BITS=8.
  - Counter width constant (4 bits).
- Sub-module sync_edge_m:
  - Parameterised SYNC_STAGES synchronizer plus rise/fall pulse outputs.
  - Instantiated twice (clk, latch).
- Per-controller shift registers in a generate loop inside the top.

Test Plan:
- Reset with buttons=8'hA5 -> all data_B=1, latch_done=shift_done=0; after release, state IDLE.
- buttons[0]=8'hA5, buttons[1]=8'h3C; latch pulse then 8 clocks -> data_B0 reads (inverted) 1,0,1,0,0,1,0,1 and data_B1 reads 0,0,1,1,1,1,0,0; one latch_done, one shift_done on the 8th edge; data high afterwards.
- 10 clocks after latch -> bits 9-10 read 1 (data_B high), counter holds at 8, a single shift_done.
- Re-latch after 3 clocks with buttons=8'hFF -> frame restarts, 8 further clocks all read pressed (data_B=0), no shift_done from the aborted frame.
- Change buttons from 8'h81 to 8'h00 mid-shift -> remaining bits still follow 8'h81; assert rst mid-frame -> data_B=1 in the same cycle, IDLE.
- TURBO_EN, TURBO_PERIOD=2, turbo_mask=8'h80, buttons=8'h80:
  - Frames 0-1 read bit7 pressed.
  - Frames 2-3 read bit7 released.
  - Frame 4 reads pressed again.
